// File: rtl/global_defs.sv
// global_defs: shared types and constants for the memory-request path.
//   parsed_op_t    - opcode produced by the request parser
//   dram_cmd_t     - DDR4 command issued by dram_cmd_issuer
//   issuer_state_t - dram_cmd_issuer sequencing states
//   ADDRESS_WIDTH and the DDR4 address field positions/widths
package global_defs;

  localparam int unsigned ADDRESS_WIDTH = 33;

  typedef enum logic [1:0] {
    DATA_READ         = 2'd0,
    DATA_WRITE        = 2'd1,
    INSTRUCTION_FETCH = 2'd2
  } parsed_op_t;

  typedef enum logic [1:0] {
    ACT = 2'd0,
    PRE = 2'd1,
    RD  = 2'd2,
    WR  = 2'd3
  } dram_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    WAIT_RP,
    ACTIVATE,
    WAIT_RCD,
    ACCESS,
    DATA
  } issuer_state_t;

  // Byte address -> DDR4 fields. Column is split: {[17:11],[5:3]}.
  localparam int unsigned ROW_LSB    = 18;
  localparam int unsigned ROW_W      = 15;
  localparam int unsigned COL_HI_LSB = 11;
  localparam int unsigned COL_HI_W   = 7;
  localparam int unsigned COL_LO_LSB = 3;
  localparam int unsigned COL_LO_W   = 3;
  localparam int unsigned COL_W      = COL_HI_W + COL_LO_W;
  localparam int unsigned BA_LSB     = 9;
  localparam int unsigned BA_W       = 2;
  localparam int unsigned BG_LSB     = 6;
  localparam int unsigned BG_W       = 2;
  localparam int unsigned BANK_W     = BG_W + BA_W;
  localparam int unsigned NUM_BANKS  = 1 << BANK_W;

endpackage

// File: rtl/bank_tracker.sv
// bank_tracker: per-bank open-row table and tRAS guard for dram_cmd_issuer.
// Ports:
//   CPU_clk, rst_n      clock, asynchronous active-low reset
//   tick_i              DIMM tick qualifier; tRAS counters decrement on it
//   lkp_bank_i/_row_i   lookup bank {bg,ba} and row -> hit_o/empty_o/miss_o
//   ras_bank_i          bank whose tRAS guard is reported on ras_ok_o
//   act_i               mark upd_bank_i open at upd_row_i, restart its tRAS
//   pre_i               mark upd_bank_i closed
module bank_tracker
  import global_defs::*;
#(
  parameter int unsigned T_RAS = 52
) (
  input  logic              CPU_clk,
  input  logic              rst_n,
  input  logic              tick_i,
  input  logic [BANK_W-1:0] lkp_bank_i,
  input  logic [ROW_W-1:0]  lkp_row_i,
  output logic              hit_o,
  output logic              empty_o,
  output logic              miss_o,
  input  logic [BANK_W-1:0] ras_bank_i,
  output logic              ras_ok_o,
  input  logic              act_i,
  input  logic              pre_i,
  input  logic [BANK_W-1:0] upd_bank_i,
  input  logic [ROW_W-1:0]  upd_row_i
);

  logic [NUM_BANKS-1:0] open_q;
  logic [ROW_W-1:0]     row_q [NUM_BANKS];
  logic [7:0]           ras_q [NUM_BANKS];

  always_comb begin
    empty_o = !open_q[lkp_bank_i];
    hit_o   = open_q[lkp_bank_i] && (row_q[lkp_bank_i] == lkp_row_i);
    miss_o  = open_q[lkp_bank_i] && (row_q[lkp_bank_i] != lkp_row_i);
    // Sampled on a tick edge: a value of 1 reaches 0 on that very tick,
    // so PRE may issue there and ACT->PRE spacing is exactly T_RAS ticks.
    ras_ok_o = (ras_q[ras_bank_i] <= 8'd1);
  end

  always_ff @(posedge CPU_clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= '0;
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        row_q[i] <= '0;
        ras_q[i] <= '0;
      end
    end else begin
      if (tick_i) begin
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
          if (ras_q[i] != 8'd0) ras_q[i] <= ras_q[i] - 8'd1;
        end
      end
      if (act_i) begin
        open_q[upd_bank_i] <= 1'b1;
        row_q[upd_bank_i]  <= upd_row_i;
        ras_q[upd_bank_i]  <= 8'(T_RAS);
      end
      if (pre_i) open_q[upd_bank_i] <= 1'b0;
    end
  end

endmodule

// File: rtl/dram_cmd_issuer.sv
// dram_cmd_issuer: consumer of the memory-request queue. Takes one request
// at a time, decodes it to DDR4 bg/ba/row/col and issues PRE/ACT/RD/WR under
// an open-page policy on DIMM ticks (half the CPU_clk rate).
// Ports:
//   CPU_clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake (ready only while IDLE)
//   req_opcode, req_address   request contents, latched on accept
//   cmd_valid                 one-CPU_clk command strobe
//   cmd_type/bg/ba/row/col    command fields (row for ACT, col for RD/WR)
//   done                      one-CPU_clk pulse at end of the data burst
// Build option: define CMD_TRACE_EN to print each issued command.
module dram_cmd_issuer
  import global_defs::*;
#(
  parameter int unsigned T_RCD   = 24,
  parameter int unsigned T_RP    = 24,
  parameter int unsigned T_RAS   = 52,
  parameter int unsigned T_CL    = 24,
  parameter int unsigned T_CWL   = 20,
  parameter int unsigned T_BURST = 4
) (
  input  logic                     CPU_clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  parsed_op_t               req_opcode,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  output logic                     cmd_valid,
  output dram_cmd_t                cmd_type,
  output logic [BG_W-1:0]          cmd_bg,
  output logic [BA_W-1:0]          cmd_ba,
  output logic [ROW_W-1:0]         cmd_row,
  output logic [COL_W-1:0]         cmd_col,
  output logic                     done
);

  localparam int unsigned WAIT_W = 8;

  issuer_state_t       state_q;
  logic                dimm_ph_q;
  logic                wr_q;
  logic [BG_W-1:0]     bg_q;
  logic [BA_W-1:0]     ba_q;
  logic [ROW_W-1:0]    row_q;
  logic [COL_W-1:0]    col_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                req_ready_q, cmd_valid_q, done_q;
  dram_cmd_t           cmd_type_q;
  logic [BG_W-1:0]     cmd_bg_q;
  logic [BA_W-1:0]     cmd_ba_q;
  logic [ROW_W-1:0]    cmd_row_q;
  logic [COL_W-1:0]    cmd_col_q;

  logic                tick;
  logic [BANK_W-1:0]   req_bank;
  logic [ROW_W-1:0]    req_row;
  logic [COL_W-1:0]    req_col;
  logic                hit, empty, miss, ras_ok;
  logic                issue_act, issue_pre;
  logic                unused_addr;

  assign tick        = dimm_ph_q;
  assign req_bank    = {req_address[BG_LSB +: BG_W], req_address[BA_LSB +: BA_W]};
  assign req_row     = req_address[ROW_LSB +: ROW_W];
  assign req_col     = {req_address[COL_HI_LSB +: COL_HI_W], req_address[COL_LO_LSB +: COL_LO_W]};
  assign unused_addr = ^{req_address[8], req_address[2:0]};

  assign issue_act = (state_q == ACTIVATE) && tick;
  assign issue_pre = (state_q == PRECHARGE) && tick && ras_ok;

  bank_tracker #(
    .T_RAS (T_RAS)
  ) u_bank_tracker (
    .CPU_clk    (CPU_clk),
    .rst_n      (rst_n),
    .tick_i     (tick),
    .lkp_bank_i (req_bank),
    .lkp_row_i  (req_row),
    .hit_o      (hit),
    .empty_o    (empty),
    .miss_o     (miss),
    .ras_bank_i ({bg_q, ba_q}),
    .ras_ok_o   (ras_ok),
    .act_i      (issue_act),
    .pre_i      (issue_pre),
    .upd_bank_i ({bg_q, ba_q}),
    .upd_row_i  (row_q)
  );

  // Wait states hand over on the non-tick edge where wait_q==1, so the next
  // command issues on the expiry tick itself: spacing is exactly N ticks.
  always_ff @(posedge CPU_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dimm_ph_q   <= 1'b0;
      wr_q        <= 1'b0;
      bg_q        <= '0;
      ba_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      wait_q      <= '0;
      req_ready_q <= 1'b1;
      cmd_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cmd_type_q  <= ACT;
      cmd_bg_q    <= '0;
      cmd_ba_q    <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
    end else begin
      dimm_ph_q   <= ~dimm_ph_q;
      cmd_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cmd_type_q  <= ACT;
      cmd_bg_q    <= '0;
      cmd_ba_q    <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      if (tick && (wait_q != '0)) wait_q <= wait_q - WAIT_W'(1);

      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
`ifndef SYNTHESIS
            if (!(req_opcode inside {DATA_READ, DATA_WRITE, INSTRUCTION_FETCH}))
              $error("dram_cmd_issuer: illegal opcode %0d, treated as read", req_opcode);
`endif
            wr_q        <= (req_opcode == DATA_WRITE);
            bg_q        <= req_address[BG_LSB +: BG_W];
            ba_q        <= req_address[BA_LSB +: BA_W];
            row_q       <= req_row;
            col_q       <= req_col;
            req_ready_q <= 1'b0;
            if (hit)        state_q <= ACCESS;
            else if (empty) state_q <= ACTIVATE;
            else if (miss)  state_q <= PRECHARGE;
          end
        end
        PRECHARGE: begin
          if (issue_pre) begin
            cmd_valid_q <= 1'b1;
            cmd_type_q  <= PRE;
            cmd_bg_q    <= bg_q;
            cmd_ba_q    <= ba_q;
            wait_q      <= WAIT_W'(T_RP);
            state_q     <= WAIT_RP;
          end
        end
        WAIT_RP: begin
          if (!tick && (wait_q == WAIT_W'(1))) state_q <= ACTIVATE;
        end
        ACTIVATE: begin
          if (issue_act) begin
            cmd_valid_q <= 1'b1;
            cmd_type_q  <= ACT;
            cmd_bg_q    <= bg_q;
            cmd_ba_q    <= ba_q;
            cmd_row_q   <= row_q;
            wait_q      <= WAIT_W'(T_RCD);
            state_q     <= WAIT_RCD;
          end
        end
        WAIT_RCD: begin
          if (!tick && (wait_q == WAIT_W'(1))) state_q <= ACCESS;
        end
        ACCESS: begin
          if (tick) begin
            cmd_valid_q <= 1'b1;
            cmd_type_q  <= wr_q ? WR : RD;
            cmd_bg_q    <= bg_q;
            cmd_ba_q    <= ba_q;
            cmd_col_q   <= col_q;
            wait_q      <= wr_q ? WAIT_W'(T_CWL + T_BURST) : WAIT_W'(T_CL + T_BURST);
            state_q     <= DATA;
          end
        end
        DATA: begin
          if (tick && (wait_q == WAIT_W'(1))) begin
            done_q      <= 1'b1;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_type  = cmd_type_q;
  assign cmd_bg    = cmd_bg_q;
  assign cmd_ba    = cmd_ba_q;
  assign cmd_row   = cmd_row_q;
  assign cmd_col   = cmd_col_q;
  assign done      = done_q;

`ifdef CMD_TRACE_EN
  logic [63:0] cyc_q;

  always_ff @(posedge CPU_clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_q + 64'd1;
  end

  always_ff @(posedge CPU_clk) begin
    if (rst_n && cmd_valid_q)
      $display("%0d %s %0d %0d 0x%h", cyc_q, cmd_type_q.name(), cmd_bg_q, cmd_ba_q,
               (cmd_type_q == ACT) ? cmd_row_q : ROW_W'(cmd_col_q));
  end
`endif

endmodule

// File: tb/tb_dram_cmd_issuer.sv
module tb_dram_cmd_issuer;
  import global_defs::*;

  localparam int unsigned T_RCD   = 24;
  localparam int unsigned T_RP    = 24;
  localparam int unsigned T_RAS   = 52;
  localparam int unsigned T_CL    = 24;
  localparam int unsigned T_CWL   = 20;
  localparam int unsigned T_BURST = 4;

  logic             CPU_clk = 1'b0;
  logic             rst_n   = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  parsed_op_t       req_opcode = DATA_READ;
  logic [32:0]      req_address = '0;
  logic             cmd_valid;
  dram_cmd_t        cmd_type;
  logic [1:0]       cmd_bg, cmd_ba;
  logic [14:0]      cmd_row;
  logic [9:0]       cmd_col;
  logic             done;

  dram_cmd_issuer #(
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS),
    .T_CL(T_CL), .T_CWL(T_CWL), .T_BURST(T_BURST)
  ) dut (
    .CPU_clk(CPU_clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_address(req_address),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .done(done)
  );

  always #5 CPU_clk = ~CPU_clk;

  // CPU_clk edges since reset release; the DIMM tick falls on even edges.
  int unsigned edge_n;
  always @(posedge CPU_clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  typedef struct {
    bit          is_done;
    dram_cmd_t   ty;
    logic [1:0]  bg, ba;
    logic [14:0] row;
    logic [9:0]  col;
    int unsigned at;
  } exp_t;

  exp_t        expq[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: open-row table and edge of the last ACT per bank.
  bit          m_open[16];
  logic [14:0] m_row[16];
  int unsigned m_act[16];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=0x%0h want=0x%0h", nm, got, want);
  endtask

  function automatic void push_ev(bit d, dram_cmd_t t, logic [1:0] g, logic [1:0] b,
                                  logic [14:0] r, logic [9:0] c, int unsigned at);
    exp_t e;
    e.is_done = d; e.ty = t; e.bg = g; e.ba = b; e.row = r; e.col = c; e.at = at;
    expq.push_back(e);
  endfunction

  // Schedule every output event of a request accepted on edge a.
  function automatic void model_push(parsed_op_t op, logic [32:0] addr, int unsigned a);
    logic [1:0]  g, b;
    logic [14:0] r;
    logic [9:0]  c;
    int unsigned bk, t, acc, lim;
    bit          wr;
    g  = addr[7:6];
    b  = addr[10:9];
    r  = addr[32:18];
    c  = {addr[17:11], addr[5:3]};
    bk = {28'd0, g, b};
    wr = (op == DATA_WRITE);
    t  = a + (((a % 2) == 0) ? 2 : 1);
    if (m_open[bk] && m_row[bk] == r) begin
      acc = t;
    end else begin
      if (m_open[bk]) begin
        lim = m_act[bk] + 2 * T_RAS;
        if (lim > t) t = lim;
        push_ev(0, PRE, g, b, '0, '0, t);
        t = t + 2 * T_RP;
      end
      push_ev(0, ACT, g, b, r, '0, t);
      m_open[bk] = 1;
      m_row[bk]  = r;
      m_act[bk]  = t;
      acc = t + 2 * T_RCD;
    end
    push_ev(0, wr ? WR : RD, g, b, '0, c, acc);
    push_ev(1, ACT, '0, '0, '0, '0, acc + 2 * ((wr ? T_CWL : T_CL) + T_BURST));
  endfunction

  // Monitor: pops and compares whenever the DUT strobes cmd_valid or done.
  initial begin
    exp_t e;
    forever begin
      @(negedge CPU_clk);
      if (rst_n && (cmd_valid || done)) begin
        n_checks++;
        if (expq.size() == 0) begin
          $display("FAIL unexpected_output edge=%0d cmd_valid=%0d type=%s done=%0d",
                   edge_n, cmd_valid, cmd_type.name(), done);
        end else begin
          e = expq.pop_front();
          if (e.is_done ? (done && !cmd_valid && e.at == edge_n)
                        : (cmd_valid && !done && cmd_type == e.ty && cmd_bg == e.bg &&
                           cmd_ba == e.ba && cmd_row == e.row && cmd_col == e.col &&
                           e.at == edge_n))
            n_pass++;
          else
            $display("FAIL event got edge=%0d valid=%0d done=%0d %s bg=%0d ba=%0d row=%0d col=%0d want edge=%0d done=%0d %s bg=%0d ba=%0d row=%0d col=%0d",
                     edge_n, cmd_valid, done, cmd_type.name(), cmd_bg, cmd_ba, cmd_row, cmd_col,
                     e.at, e.is_done, e.ty.name(), e.bg, e.ba, e.row, e.col);
        end
      end
    end
  end

  // Called at a negedge. Unaligned requests sit on the bus while the DUT is
  // busy, so they also exercise "valid ignored while not ready".
  task automatic do_req(input parsed_op_t op, input logic [32:0] addr,
                        input int unsigned gap, input bit align);
    int unsigned w;
    if (gap > 0) begin
      req_valid = 1'b0;
      repeat (gap) @(negedge CPU_clk);
    end
    req_opcode  = op;
    req_address = addr;
    req_valid   = !align;
    w = 0;
    while (!(req_ready && (!align || (edge_n % 2) == 1))) begin
      @(negedge CPU_clk);
      w++;
      if (w > 4000) begin
        n_checks++;
        $display("FAIL accept_timeout got=ready_%0d want=ready_1", req_ready);
        req_valid = 1'b0;
        return;
      end
    end
    req_valid = 1'b1;
    model_push(op, addr, edge_n + 1);
    @(negedge CPU_clk);
    req_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    check({tag, "_cmd_valid"}, {63'd0, cmd_valid}, 64'd0);
    check({tag, "_done"},      {63'd0, done},      64'd0);
    check({tag, "_fields"},    {33'd0, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col}, 64'd0);
  endtask

  task automatic drain(input string tag);
    int unsigned w;
    w = 0;
    while (expq.size() != 0 && w < 5000) begin
      @(negedge CPU_clk);
      w++;
    end
    check({tag, "_drain_left"}, 64'(expq.size()), 64'd0);
  endtask

  function automatic logic [32:0] mk_addr(logic [14:0] r, logic [1:0] g, logic [1:0] b);
    logic [32:0] a;
    a = '0;
    a[32:18] = r;
    a[10:9]  = b;
    a[7:6]   = g;
    return a;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=no_finish want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [32:0] a;
    int unsigned w;
    for (int i = 0; i < 16; i++) begin m_open[i] = 0; m_row[i] = '0; m_act[i] = 0; end

    #12;
    check_reset_vals("reset");
    @(negedge CPU_clk);
    rst_n = 1'b1;

    // Directed: empty-bank read on a tick edge, then a second bank.
    do_req(DATA_READ,  33'h0_0000_0000, 0, 1);
    do_req(DATA_READ,  33'h0_0000_0040, 0, 0);
    // Write opens bank {bg0,ba1}; the following miss must hold PRE for tRAS.
    do_req(DATA_WRITE, mk_addr(15'd0, 2'd0, 2'd1), 0, 0);
    do_req(DATA_READ,  mk_addr(15'd1, 2'd0, 2'd1), 0, 0);
    // Miss on bank 0 long after its ACT, then fetch hitting bg1.
    do_req(DATA_WRITE, 33'h0_0004_0000, 3, 0);
    do_req(INSTRUCTION_FETCH, 33'h0_0000_0040, 0, 1);
    drain("directed");

    // Random: few rows and banks so hits, misses and empties all occur.
    for (int n = 0; n < 40; n++) begin
      a = '0;
      a[32:18] = 15'($urandom_range(0, 3));
      a[17:11] = 7'($urandom);
      a[10:9]  = 2'($urandom);
      a[8]     = 1'($urandom);
      a[7:6]   = 2'($urandom_range(0, 1));
      a[5:3]   = 3'($urandom);
      a[2:0]   = 3'($urandom);
      do_req(parsed_op_t'(2'($urandom_range(0, 2))), a,
             ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : 0,
             1'($urandom));
    end
    drain("random");

    // Reset while waiting on tRCD: bg3 is untouched so far, so ACT first.
    a = mk_addr(15'd9, 2'd3, 2'd1);
    do_req(DATA_READ, a, 0, 0);
    w = 0;
    while (expq.size() > 2 && w < 500) begin @(negedge CPU_clk); w++; end
    check("rst_wait_act_seen", 64'(expq.size()), 64'd2);
    repeat (10) @(negedge CPU_clk);
    @(posedge CPU_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    expq.delete();
    for (int i = 0; i < 16; i++) m_open[i] = 0;
    @(negedge CPU_clk);
    rst_n = 1'b1;
    do_req(DATA_READ, a, 0, 0);
    drain("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
